// File: rtl/mult_seq_ctrl_if.sv
// Start/busy/done handshake plus operands and product for the sequential multiplier.
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic               start;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] P;

    modport master (output start, A, B, input busy, done, P);
    modport slave  (input start, A, B, output busy, done, P);
endinterface

// File: rtl/mult_seq_ctrl.sv
// Shift-and-add unsigned multiplier: one adder shared over WIDTH cycles,
// full 2*WIDTH-bit product, start/busy/done handshake.
module mult_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_seq_ctrl_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] mcand, acc, acc_sum, prod;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic               accept, last;

    assign acc_sum = acc + (mplier[0] ? mcand : '0);
    assign last    = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // DONE accepts a new start directly so back-to-back ops lose no cycle.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: if (bus.start) begin
                state_nxt = RUN;
                accept    = 1'b1;
            end
            RUN:  if (last) state_nxt = DONE;
            DONE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    accept    = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            prod   <= '0;
        end else if (accept) begin
            mcand  <= {{WIDTH{1'b0}}, bus.A};
            mplier <= bus.B;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            // Product register includes the add done in the final cycle.
            if (last) prod <= acc_sum;
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.P    = prod;
endmodule
